// File: rtl/mux_gate_sched.sv
// mux_gate_sched: round-robin scheduler that time-shares one external 1-bit
// XOR/XNOR gate among NREQ requesters. The winner's operands are latched and
// streamed LSB-first through the gate, one bit per cycle. The WIDTH-bit result
// is returned with a one-cycle done pulse.
// Optional build macro SPECIAL_GATE_CHECK_EN adds a sticky gate_err output.
// It flags an inconsistent response from the external gate.
module mux_gate_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  input  logic [NREQ-1:0]         mode,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [ID_W-1:0]         done_id,
  output logic [WIDTH-1:0]        result,
  output logic                    gate_a,
  output logic                    gate_b,
  input  logic                    gate_xor_in,
  input  logic                    gate_xnor_in
`ifdef SPECIAL_GATE_CHECK_EN
  ,
  output logic                    gate_err
`endif
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Control state
  logic [1:0]       state_q,   state_d;
  logic [ID_W-1:0]  ptr_q,     ptr_d;
  logic [ID_W-1:0]  id_q,      id_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [NREQ-1:0]  gnt_q,     gnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic [WIDTH-1:0] result_q,  result_d;

  // Datapath state (no reset; always written before it is used)
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic             mode_q;

  // Arbitration and bit-capture helpers
  logic             arb_found;
  logic [ID_W-1:0]  arb_win;
  logic [ID_W-1:0]  cand;
  logic             cap_bit;
  logic             idx_last;

  // Round-robin search: first set req bit starting just after ptr_q.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NREQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_win   = cand;
      end
    end
  end

  // Select the gate output for the latched mode and merge it into the accumulator.
  always_comb begin
    cap_bit  = mode_q ? gate_xnor_in : gate_xor_in;
    idx_last = (idx_q == IDX_W'(WIDTH - 1));
    acc_d    = acc_q;
    if (state_q == ST_SHIFT) begin
      acc_d[idx_q] = cap_bit;
    end
  end

  // Gate operand bits come from the latched words, and only while shifting.
  always_comb begin
    gate_a = 1'b0;
    gate_b = 1'b0;
    if (state_q == ST_SHIFT) begin
      gate_a = a_q[idx_q];
      gate_b = b_q[idx_q];
    end
  end

  // FSM next-state: IDLE arbitrates, SHIFT streams bits, DONE reports and rotates ptr.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d = ST_SHIFT;
          id_d    = arb_win;
          idx_d   = '0;
          gnt_d   = NREQ'(1) << arb_win;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_last) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          done_id_d = id_q;
          result_d  = acc_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = id_q;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control registers; synchronous active-low reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= ID_W'(NREQ - 1);
      id_q      <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
    end
  end

  // Operand latch on grant and per-bit accumulation during SHIFT.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && arb_found) begin
      a_q    <= op_a[arb_win*WIDTH +: WIDTH];
      b_q    <= op_b[arb_win*WIDTH +: WIDTH];
      mode_q <= mode[arb_win];
    end
    if (state_q == ST_SHIFT) begin
      acc_q <= acc_d;
    end
  end

`ifdef SPECIAL_GATE_CHECK_EN
  logic err_q;

  // Sticky flag: the gate outputs must be complementary and XOR must match the inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == ST_SHIFT &&
                 ((gate_xor_in == gate_xnor_in) || (gate_xor_in != (gate_a ^ gate_b)))) begin
      err_q <= 1'b1;
    end
  end

  assign gate_err = err_q;
`endif

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;

endmodule

// File: tb/tb_mux_gate_sched.sv
// Directed bench for mux_gate_sched (NREQ=4, WIDTH=8) with a behavioural
// XOR/XNOR gate stub that can be forced to give a bad XNOR output.
module tb_mux_gate_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a, op_b;
  logic [NREQ-1:0]       mode;
  logic [NREQ-1:0]       gnt;
  logic                  busy, done;
  logic [ID_W-1:0]       done_id;
  logic [WIDTH-1:0]      result;
  logic                  gate_a, gate_b;
  logic                  gate_xor_in, gate_xnor_in;
  logic                  fault;
`ifdef SPECIAL_GATE_CHECK_EN
  logic                  gate_err;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cnt;

  always #5 clk = ~clk;

  assign gate_xor_in  = gate_a ^ gate_b;
  assign gate_xnor_in = fault ? gate_xor_in : ~gate_xor_in;

  mux_gate_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .op_a         (op_a),
    .op_b         (op_b),
    .mode         (mode),
    .gnt          (gnt),
    .busy         (busy),
    .done         (done),
    .done_id      (done_id),
    .result       (result),
    .gate_a       (gate_a),
    .gate_b       (gate_b),
    .gate_xor_in  (gate_xor_in),
    .gate_xnor_in (gate_xnor_in)
`ifdef SPECIAL_GATE_CHECK_EN
    ,
    .gate_err     (gate_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Advance until done (bounded) and check latency, id, result and grant.
  task automatic wait_done(input int exp_n, input logic [NREQ-1:0] exp_gnt,
                           input int exp_id, input logic [7:0] exp_res, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
    check({tag, "_done"},    32'(done), 32'd1);
    check({tag, "_lat"},     32'(n), 32'(exp_n));
    check({tag, "_id"},      32'(done_id), 32'(exp_id));
    check({tag, "_result"},  32'(result), 32'(exp_res));
    check({tag, "_gnt"},     32'(gnt), 32'(exp_gnt));
    check({tag, "_onehot"},  32'($onehot(gnt)), 32'd1);
    check({tag, "_gate_a0"}, 32'(gate_a), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    mode  = '0;
    fault = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_gate_a", 32'(gate_a), 32'd0);
    check("rst_gate_b", 32'(gate_b), 32'd0);
`ifdef SPECIAL_GATE_CHECK_EN
    check("rst_gate_err", 32'(gate_err), 32'd0);
`endif
    rst_n = 1'b1;

    // Requester 0, XOR: A5 ^ 0F = AA
    op_a[7:0]   = 8'hA5;
    op_b[7:0]   = 8'h0F;
    op_a[15:8]  = 8'h3C;
    op_b[15:8]  = 8'hC3;
    mode        = 4'b0000;
    req         = 4'b0001;
    tick();
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_done0", 32'(done), 32'd0);
    check("t1_gate_a_b0", 32'(gate_a), 32'd1);
    check("t1_gate_b_b0", 32'(gate_b), 32'd1);
    tick();
    check("t1_gate_a_b1", 32'(gate_a), 32'd0);
    check("t1_gate_b_b1", 32'(gate_b), 32'd1);
    wait_done(7, 4'b0001, 0, 8'hAA, "t1");
    req = '0;
    tick();
    check("t1_pulse", 32'(done), 32'd0);
    check("t1_busy_off", 32'(busy), 32'd0);
    check("t1_gnt_off", 32'(gnt), 32'd0);
    check("t1_result_hold", 32'(result), 32'hAA);

    // Requester 2, XNOR: ~(A5 ^ 0F) = 55
    op_a[23:16] = 8'hA5;
    op_b[23:16] = 8'h0F;
    mode        = 4'b0100;
    req         = 4'b0100;
    tick();
    check("t2_gnt", 32'(gnt), 32'b0100);
    wait_done(8, 4'b0100, 2, 8'h55, "t2");
    req = '0;
    tick();

    // All four requesting after reset: rotation 0,1,2,3,0, 10 cycles apart
    do_reset();
    op_a = {4{8'hFF}};
    op_b = '0;
    mode = '0;
    req  = 4'b1111;
    wait_done(9,  4'b0001, 0, 8'hFF, "t3a");
    wait_done(10, 4'b0010, 1, 8'hFF, "t3b");
    wait_done(10, 4'b0100, 2, 8'hFF, "t3c");
    wait_done(10, 4'b1000, 3, 8'hFF, "t3d");
    wait_done(10, 4'b0001, 0, 8'hFF, "t3e");

    // Reset mid-operation aborts and restores the pointer
    req = 4'b0001;
    tick();
    check("t4_idle_busy", 32'(busy), 32'd0);
    tick();
    check("t4_gnt", 32'(gnt), 32'b0001);
    check("t4_result_before", 32'(result), 32'hFF);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("t4_rst_gnt", 32'(gnt), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_result", 32'(result), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    req   = '0;
    cnt   = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt += int'(done) + int'(busy);
    end
    check("t4_no_done", 32'(cnt), 32'd0);
    req = 4'b0011;
    tick();
    check("t4_ptr_reset", 32'(gnt), 32'b0001);
    wait_done(8, 4'b0001, 0, 8'hFF, "t4a");
    req = 4'b0010;
    tick();
    tick();
    check("t4_req1_gnt", 32'(gnt), 32'b0010);
    wait_done(8, 4'b0010, 1, 8'hFF, "t4b");
    req = '0;
    tick();

    // Request and operands dropped mid-shift are ignored
    op_a[7:0] = 8'hA5;
    op_b[7:0] = 8'h0F;
    mode      = '0;
    req       = 4'b0001;
    tick();
    check("t5_gnt", 32'(gnt), 32'b0001);
    tick();
    tick();
    req       = '0;
    op_a[7:0] = 8'h00;
    wait_done(6, 4'b0001, 0, 8'hAA, "t5");
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt += int'(busy) + int'(gnt != 4'b0000);
    end
    check("t5_no_regrant", 32'(cnt), 32'd0);

    // Faulty gate at bit 3 on requester 3, XNOR: 55 becomes 5D
    op_a[31:24] = 8'hA5;
    op_b[31:24] = 8'h0F;
    mode        = 4'b1000;
    req         = 4'b1000;
    tick();
    check("t6_gnt", 32'(gnt), 32'b1000);
    tick();
    tick();
    tick();
    fault = 1'b1;
`ifdef SPECIAL_GATE_CHECK_EN
    check("t6_err_before", 32'(gate_err), 32'd0);
`endif
    tick();
    fault = 1'b0;
`ifdef SPECIAL_GATE_CHECK_EN
    check("t6_err_set", 32'(gate_err), 32'd1);
`endif
    wait_done(4, 4'b1000, 3, 8'h5D, "t6");
    req = '0;
    tick();
`ifdef SPECIAL_GATE_CHECK_EN
    check("t6_err_sticky", 32'(gate_err), 32'd1);
`endif
    check("t6_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
